// File: rtl/pe_ctrl.sv
// ---------------------------------------------------------------------------
// pe_ctrl
//
// Sequences one processing element through a dot-product job. The first
// VEC_LEN words of the input stream go into the PE weight buffer. The PE
// accumulator is then cleared, and VEC_LEN operand words are issued one at a
// time. Each issue waits for the PE result strobe before the next one goes
// out. The final accumulator value is captured as the job result. If the PE
// stays silent for TIMEOUT cycles after an issue, the job is aborted and
// reported with err.
//
// Ports
//   aclk       clock; all logic on the rising edge
//   areset     synchronous active-high reset
//   start      begins a job; only sampled while idle
//   busy       high whenever a job is in progress
//   done       one-cycle pulse at job end (normal or aborted)
//   err        qualifies done: 1 = aborted by timeout
//   s_valid    input stream word valid
//   s_ready    input stream word accepted when s_valid & s_ready
//   s_data     input stream data: weights first, then operands
//   pe_rst     active-high PE accumulator clear
//   pe_we      PE buffer write enable
//   pe_valid   PE operand strobe
//   pe_addr    PE buffer address (write address or operand index)
//   pe_din     PE buffer write data
//   pe_ain     PE operand
//   pe_dvalid  PE result strobe
//   pe_dout    PE accumulator value
//   result     captured dot product; holds until the next capture
// ---------------------------------------------------------------------------
module pe_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int VEC_LEN = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              pe_rst,
    output logic              pe_we,
    output logic              pe_valid,
    output logic [ADDR_W-1:0] pe_addr,
    output logic [DATA_W-1:0] pe_din,
    output logic [DATA_W-1:0] pe_ain,
    input  logic              pe_dvalid,
    input  logic [DATA_W-1:0] pe_dout,
    output logic [DATA_W-1:0] result
);

    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(VEC_LEN - 1);
    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [7:0]        tmo, tmo_nxt;

    logic              busy_nxt, done_nxt, err_nxt, s_ready_nxt;
    logic              pe_rst_nxt, pe_we_nxt, pe_valid_nxt;
    logic [ADDR_W-1:0] pe_addr_nxt;
    logic [DATA_W-1:0] pe_din_nxt, pe_ain_nxt, result_nxt;
    logic              hs;

    // s_ready is a registered copy of "state is LOAD or ISSUE", so a
    // handshake can be decided from the current outputs alone.
    assign hs = s_valid & s_ready;

    // Next-state and next-output logic. Every output is registered, so the
    // level-type outputs (busy, done, s_ready, pe_rst) are decoded from the
    // state being entered rather than the state being left.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        tmo_nxt      = tmo;
        err_nxt      = 1'b0;
        pe_we_nxt    = 1'b0;
        pe_valid_nxt = 1'b0;
        pe_addr_nxt  = pe_addr;
        pe_din_nxt   = pe_din;
        pe_ain_nxt   = pe_ain;
        result_nxt   = result;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    pe_we_nxt   = 1'b1;
                    pe_addr_nxt = cnt;
                    pe_din_nxt  = s_data;
                    if (cnt == LAST) begin
                        state_nxt = ST_CLEAR;
                    end else begin
                        cnt_nxt = cnt + ADDR_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_ISSUE;
                cnt_nxt   = '0;
            end
            ST_ISSUE: begin
                if (hs) begin
                    pe_valid_nxt = 1'b1;
                    pe_ain_nxt   = s_data;
                    pe_addr_nxt  = cnt;
                    state_nxt    = ST_WAIT;
                    tmo_nxt      = '0;
                end
            end
            ST_WAIT: begin
                // The terminal check comes before the increment, so cnt
                // never wraps inside a job.
                if (pe_dvalid) begin
                    if (cnt == LAST) begin
                        result_nxt = pe_dout;
                        state_nxt  = ST_DONE;
                        err_nxt    = 1'b0;
                    end else begin
                        cnt_nxt   = cnt + ADDR_W'(1);
                        state_nxt = ST_ISSUE;
                    end
                end else if (tmo == TMO_LAST) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_nxt = tmo + 8'd1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt    = (state_nxt != ST_IDLE);
        done_nxt    = (state_nxt == ST_DONE);
        s_ready_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_ISSUE);
        pe_rst_nxt  = (state_nxt == ST_CLEAR);
    end

    // State, counters and all outputs. Reset holds the PE accumulator in
    // clear and drops every other output.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tmo      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            s_ready  <= 1'b0;
            pe_rst   <= 1'b1;
            pe_we    <= 1'b0;
            pe_valid <= 1'b0;
            pe_addr  <= '0;
            pe_din   <= '0;
            pe_ain   <= '0;
            result   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tmo      <= tmo_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            s_ready  <= s_ready_nxt;
            pe_rst   <= pe_rst_nxt;
            pe_we    <= pe_we_nxt;
            pe_valid <= pe_valid_nxt;
            pe_addr  <= pe_addr_nxt;
            pe_din   <= pe_din_nxt;
            pe_ain   <= pe_ain_nxt;
            result   <= result_nxt;
        end
    end

endmodule

// File: tb/tb_pe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_ctrl
//
// Drives pe_ctrl with a word stream and a small PE model (weight buffer,
// integer multiply-accumulate, configurable result latency, optional
// silence from a chosen operand onward). Each job is described by a table
// record and checked against the expected dot product, write/issue order,
// handshake count and termination status.
// ---------------------------------------------------------------------------
module tb_pe_ctrl;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 6;
    localparam int VEC_LEN = 16;
    localparam int TIMEOUT = 255;

    logic              aclk = 1'b0;
    logic              areset;
    logic              start;
    logic              busy, done, err;
    logic              s_valid, s_ready;
    logic [DATA_W-1:0] s_data;
    logic              pe_rst, pe_we, pe_valid;
    logic [ADDR_W-1:0] pe_addr;
    logic [DATA_W-1:0] pe_din, pe_ain;
    logic              pe_dvalid;
    logic [DATA_W-1:0] pe_dout;
    logic [DATA_W-1:0] result;

    always #5 aclk = ~aclk;

    pe_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .VEC_LEN(VEC_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .pe_rst   (pe_rst),
        .pe_we    (pe_we),
        .pe_valid (pe_valid),
        .pe_addr  (pe_addr),
        .pe_din   (pe_din),
        .pe_ain   (pe_ain),
        .pe_dvalid(pe_dvalid),
        .pe_dout  (pe_dout),
        .result   (result)
    );

    typedef struct {
        int lat;
        bit gaps;
        int stall_at;
        bit nominal;
        bit exp_err;
        int exp_issues;
    } job_t;

    int tests = 0;
    int fails = 0;

    // Stream source state
    logic [31:0] w [VEC_LEN];
    logic [31:0] a [VEC_LEN];
    logic [31:0] stream [2*VEC_LEN];
    int  sidx = 0;
    bit  stream_en = 1'b0;
    bit  gaps = 1'b0;

    // PE model state
    int          lat = 1;
    int          stall_at = 0;
    int          issue_seen = 0;
    logic [31:0] pbuf [64];
    logic [31:0] acc = '0;
    logic [7:0]  vpipe = '0;
    logic        inj_dv = 1'b0;
    logic        accept;
    logic [31:0] prod;
    logic [2:0]  lidx;

    // Monitor state
    logic [ADDR_W-1:0] we_addr_q [$];
    logic [31:0]       we_data_q [$];
    logic [ADDR_W-1:0] iss_addr_q [$];
    logic [31:0]       iss_ain_q [$];
    int cyc = 0;
    int done_cnt = 0;
    int rst_cycles = 0;
    int hs_cnt = 0;
    int stray = 0;
    int last_issue_cyc = 0;
    int done_cyc = 0;
    bit done_err = 1'b0;

    logic [31:0] exp_result;

    // PE model: multiply-accumulate into acc, answer after lat cycles
    // (lat 0 answers combinationally in the strobe cycle).
    assign prod      = pbuf[pe_addr] * pe_ain;
    assign accept    = pe_valid && !(stall_at != 0 && issue_seen + 1 >= stall_at);
    assign lidx      = 3'((lat == 0) ? 0 : lat - 1);
    assign pe_dvalid = inj_dv | ((lat == 0) ? accept : vpipe[lidx]);
    assign pe_dout   = (lat == 0) ? acc + prod : acc;

    always @(posedge aclk) begin
        if (pe_rst) begin
            acc        <= '0;
            issue_seen <= 0;
            vpipe      <= '0;
        end else begin
            if (pe_valid) begin
                acc        <= acc + prod;
                issue_seen <= issue_seen + 1;
            end
            vpipe <= {vpipe[6:0], accept};
        end
        if (pe_we) pbuf[pe_addr] <= pe_din;
    end

    // Stream driver: advances on each observed handshake, optionally
    // inserting random bubbles; garbage data while invalid.
    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge aclk);
            if (s_valid && s_ready) sidx++;
            @(posedge aclk);
            #1;
            if (stream_en && sidx < 2*VEC_LEN && (!gaps || $urandom_range(0, 1) == 1)) begin
                s_valid = 1'b1;
                s_data  = stream[sidx];
            end else begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end
        end
    end

    // Monitor: records PE writes, issues, clears, handshakes and done.
    always @(negedge aclk) begin
        cyc++;
        if (s_valid && s_ready) hs_cnt++;
        if (pe_we) begin
            we_addr_q.push_back(pe_addr);
            we_data_q.push_back(pe_din);
        end
        if (pe_valid) begin
            iss_addr_q.push_back(pe_addr);
            iss_ain_q.push_back(pe_ain);
            last_issue_cyc = cyc;
        end
        if (pe_rst) rst_cycles++;
        if (done) begin
            done_cnt++;
            done_err = err;
            done_cyc = cyc;
        end
        if (s_ready && (pe_valid || pe_rst || done || !busy)) stray++;
        if (err && !done) stray++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dotRef();
        logic [31:0] s = '0;
        for (int i = 0; i < VEC_LEN; i++) s += w[i] * a[i];
        return s;
    endfunction

    task automatic prepare(input bit nominal);
        for (int i = 0; i < VEC_LEN; i++) begin
            if (nominal) begin
                w[i] = 32'h3f800000 + 32'(i) * 32'h0040_0000;
                a[i] = 32'h3f800000 + 32'(i) * 32'h0040_0000;
            end else begin
                w[i] = $urandom;
                a[i] = $urandom;
            end
            stream[i]           = w[i];
            stream[VEC_LEN + i] = a[i];
        end
        sidx = 0;
        we_addr_q.delete();
        we_data_q.delete();
        iss_addr_q.delete();
        iss_ain_q.delete();
        done_cnt   = 0;
        rst_cycles = 0;
        hs_cnt     = 0;
        stray      = 0;
    endtask

    // Runs one job end to end. With disturb set, start and a stray result
    // strobe are pulsed during LOAD, and start again mid-issue.
    task automatic applyStimulus(input job_t j, input bit disturb);
        int  bad;
        bit  d1 = 1'b0;
        bit  d2 = 1'b0;
        step();
        stream_en = 1'b0;
        step();
        gaps     = j.gaps;
        lat      = j.lat;
        stall_at = j.stall_at;
        prepare(j.nominal);
        stream_en = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int budget = 0; budget < 3000 && done_cnt == 0; budget++) begin
            @(negedge aclk);
            if (disturb && !d1 && we_addr_q.size() >= 3) begin
                d1 = 1'b1;
                step();
                inj_dv = 1'b1;
                start  = 1'b1;
                step();
                inj_dv = 1'b0;
                start  = 1'b0;
            end
            if (disturb && !d2 && iss_addr_q.size() >= 4) begin
                d2 = 1'b1;
                step();
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
        repeat (3) step();
        stream_en = 1'b0;
        repeat (2) step();

        checkOutput("done_count", done_cnt, 1);
        checkOutput("err_flag", 32'(done_err), 32'(j.exp_err));
        checkOutput("busy_after", 32'(busy), 0);
        checkOutput("we_count", we_addr_q.size(), VEC_LEN);
        bad = 0;
        for (int i = 0; i < we_addr_q.size() && i < VEC_LEN; i++)
            if (we_addr_q[i] !== ADDR_W'(i) || we_data_q[i] !== w[i]) bad++;
        checkOutput("we_order", bad, 0);
        checkOutput("issue_count", iss_addr_q.size(), j.exp_issues);
        bad = 0;
        for (int i = 0; i < iss_addr_q.size() && i < VEC_LEN; i++)
            if (iss_addr_q[i] !== ADDR_W'(i) || iss_ain_q[i] !== a[i]) bad++;
        checkOutput("issue_order", bad, 0);
        checkOutput("pe_rst_cycles", rst_cycles, 1);
        checkOutput("handshakes", hs_cnt, VEC_LEN + j.exp_issues);
        checkOutput("ready_err_stray", stray, 0);
        if (!j.exp_err) exp_result = dotRef();
        checkOutput("result", result, exp_result);
        if (j.exp_err) checkOutput("timeout_cycles", done_cyc - last_issue_cyc, TIMEOUT);
    endtask

    initial begin
        job_t jobs [8];
        job_t dj;
        jobs[0] = '{3, 1'b0, 0, 1'b1, 1'b0, 16};   // nominal
        jobs[1] = '{3, 1'b1, 0, 1'b1, 1'b0, 16};   // stream gaps, same data
        jobs[2] = '{2, 1'b0, 5, 1'b0, 1'b1, 5};    // PE silent on operand 5
        jobs[3] = '{0, 1'b0, 0, 1'b0, 1'b0, 16};   // zero-latency PE
        jobs[4] = '{1, 1'b1, 0, 1'b0, 1'b0, 16};
        jobs[5] = '{5, 1'b1, 0, 1'b0, 1'b0, 16};
        jobs[6] = '{0, 1'b1, 0, 1'b0, 1'b0, 16};
        jobs[7] = '{4, 1'b0, 1, 1'b0, 1'b1, 1};    // PE silent on first operand

        areset = 1'b1;
        start  = 1'b0;
        repeat (3) step();
        @(negedge aclk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_s_ready", 32'(s_ready), 0);
        checkOutput("rst_pe_rst", 32'(pe_rst), 1);
        checkOutput("rst_pe_we", 32'(pe_we), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_result", result, 0);
        step();
        areset = 1'b0;
        repeat (2) step();
        checkOutput("idle_pe_rst", 32'(pe_rst), 0);
        exp_result = '0;

        for (int k = 0; k < 8; k++) begin
            applyStimulus(jobs[k], 1'b0);
        end

        // Reset in the middle of LOAD, after weight 7 has been written.
        lat = 3; gaps = 1'b0; stall_at = 0;
        prepare(1'b1);
        stream_en = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int budget = 0; budget < 500 && we_addr_q.size() < 8; budget++) @(negedge aclk);
        checkOutput("reached_weight7", 32'(we_addr_q.size() >= 8), 1);
        step();
        areset    = 1'b1;
        stream_en = 1'b0;
        step();
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_s_ready", 32'(s_ready), 0);
        checkOutput("midrst_pe_we", 32'(pe_we), 0);
        checkOutput("midrst_pe_rst", 32'(pe_rst), 1);
        repeat (4) step();
        checkOutput("midrst_no_done", done_cnt, 0);
        checkOutput("midrst_busy_idle", 32'(busy), 0);
        exp_result = '0;
        applyStimulus(jobs[0], 1'b0);

        // Stray result strobe while idle changes nothing.
        step();
        inj_dv = 1'b1;
        step();
        inj_dv = 1'b0;
        @(negedge aclk);
        checkOutput("idle_dv_busy", 32'(busy), 0);
        checkOutput("idle_dv_result", result, exp_result);

        dj = '{2, 1'b1, 0, 1'b0, 1'b0, 16};
        applyStimulus(dj, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
